// File: rtl/acc_drain_pkg.sv
// Shared MAC datapath constants and the accumulator drain FSM encoding.
package acc_drain_pkg;

    localparam int MAC_INT_WIDTH   = 32;
    localparam int MAC_ACC_WIDTH   = 48;
    localparam int MAC_OUT_WIDTH   = 8;
    localparam int MAC_SHIFT_WIDTH = 5;

    typedef enum logic [0:0] {
        ACC_DRAIN_IDLE  = 1'b0,
        ACC_DRAIN_DRAIN = 1'b1
    } acc_drain_state_e;

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: round-half-up arithmetic right shift, then signed
// saturation to OUT_W bits.
module requant_sat
    import acc_drain_pkg::*;
#(
    parameter int IN_W    = MAC_INT_WIDTH,
    parameter int OUT_W   = MAC_OUT_WIDTH,
    parameter int SHIFT_W = MAC_SHIFT_WIDTH
) (
    input  logic signed [IN_W-1:0]    x,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [OUT_W-1:0]   y,
    output logic                      sat
);

    localparam logic signed [IN_W:0] ONE   = 1;
    localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = ~MAX_V;

    logic signed [IN_W:0] xe;
    logic signed [IN_W:0] bias;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] r;

    always_comb begin
        // One extra bit of headroom so the rounding bias cannot wrap the sum.
        xe   = {x[IN_W-1], x};
        bias = '0;
        sum  = xe;
        r    = xe;
        if (shift == '0) begin
            r = xe;
        end else if (32'(shift) >= IN_W) begin
            r = x[IN_W-1] ? '1 : '0;
        end else begin
            bias = ONE << (shift - SHIFT_W'(1));
            sum  = xe + bias;
            r    = sum >>> shift;
        end

        if (r > MAX_V) begin
            y   = MAX_V[OUT_W-1:0];
            sat = 1'b1;
        end else if (r < MIN_V) begin
            y   = MIN_V[OUT_W-1:0];
            sat = 1'b1;
        end else begin
            y   = r[OUT_W-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/acc_drain.sv
// Accumulator read-out: snapshots NUM_ACC lanes in one handshake and streams
// them out one requantized beat at a time.
module acc_drain
    import acc_drain_pkg::*;
#(
    parameter int NUM_ACC = 4,
    parameter int IN_W    = MAC_INT_WIDTH,
    parameter int OUT_W   = MAC_OUT_WIDTH,
    parameter int SHIFT_W = MAC_SHIFT_WIDTH,
    localparam int IDX_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [NUM_ACC*IN_W-1:0] load_data,
    input  logic [SHIFT_W-1:0]      load_shift,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_last,
    output logic                    out_sat,
    output logic                    busy
);

    acc_drain_state_e          state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_ACC*IN_W-1:0]   snap_q, snap_d;
    logic [SHIFT_W-1:0]        shift_q, shift_d;

    logic signed [IN_W-1:0]    lane;
    logic signed [OUT_W-1:0]   rq_y;
    logic                      rq_sat;
    logic                      last_beat;

    requant_sat #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
    ) u_requant (
        .x     (lane),
        .shift (shift_q),
        .y     (rq_y),
        .sat   (rq_sat)
    );

    always_comb begin
        load_ready = (state_q == ACC_DRAIN_IDLE);
        busy       = (state_q == ACC_DRAIN_DRAIN);
        out_valid  = busy;
        lane       = snap_q[32'(idx_q)*IN_W +: IN_W];
        last_beat  = (idx_q == IDX_W'(NUM_ACC-1));
        // Beat fields are forced to zero whenever no beat is offered.
        out_data   = out_valid ? rq_y : '0;
        out_idx    = out_valid ? idx_q : '0;
        out_last   = out_valid && last_beat;
        out_sat    = out_valid && rq_sat;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        shift_d = shift_q;
        case (state_q)
            ACC_DRAIN_IDLE: begin
                if (load_valid) begin
                    snap_d  = load_data;
                    shift_d = load_shift;
                    idx_d   = '0;
                    state_d = ACC_DRAIN_DRAIN;
                end
            end
            ACC_DRAIN_DRAIN: begin
                if (out_ready) begin
                    if (last_beat) begin
                        idx_d   = '0;
                        state_d = ACC_DRAIN_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ACC_DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACC_DRAIN_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        snap_q  <= snap_d;
        shift_q <= shift_d;
    end

endmodule
